// File: rtl/fluxo_dados.sv
// fluxo_dados: datapath for the memory-sequence game. It holds the position
// counter, a 16x4 sequence ROM, the player-move register, the move comparator
// and a synchronised edge detector on the player buttons.
module fluxo_dados (
   input  logic       clock,
   input  logic       reset,
   input  logic       zeraC,
   input  logic       contaC,
   input  logic       zeraR,
   input  logic       registraR,
   input  logic [3:0] botoes,
   output logic       jogada_feita,
   output logic       igual,
   output logic       fim,
   output logic       db_tem_jogada,
   output logic [3:0] db_contagem,
   output logic [3:0] db_jogada,
   output logic [3:0] db_memoria
);

   logic [3:0] sync1_q;
   logic [3:0] botoes_s_q;
   logic       tem_q;
   logic       tem;
   logic [3:0] contagem_q, contagem_d;
   logic [3:0] jogada_q, jogada_d;
   logic [3:0] rom_dado;

   // Two-stage synchroniser for the asynchronous buttons, plus the delayed
   // "any button" flag used by the rising-edge detector.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q    <= '0;
         botoes_s_q <= '0;
         tem_q      <= 1'b0;
      end else begin
         sync1_q    <= botoes;
         botoes_s_q <= sync1_q;
         tem_q      <= tem;
      end
   end

   // Any synchronised button pressed; the pulse marks the released-to-pressed edge.
   always_comb begin
      tem          = |botoes_s_q;
      jogada_feita = tem & ~tem_q;
   end

   // Position counter next state: clear wins over increment; wraps 15 -> 0.
   always_comb begin
      contagem_d = contagem_q;
      if (zeraC)
         contagem_d = '0;
      else if (contaC)
         contagem_d = contagem_q + 4'd1;
   end

   // Move register next state: clear wins over load; multi-hot codes load as-is.
   always_comb begin
      jogada_d = jogada_q;
      if (zeraR)
         jogada_d = '0;
      else if (registraR)
         jogada_d = botoes_s_q;
   end

   // Counter and move register state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contagem_q <= '0;
         jogada_q   <= '0;
      end else begin
         contagem_q <= contagem_d;
         jogada_q   <= jogada_d;
      end
   end

   // Sequence ROM, read combinationally at the current position.
   always_comb begin
      rom_dado = 4'b0001;
      case (contagem_q)
         4'd0:  rom_dado = 4'b0001;
         4'd1:  rom_dado = 4'b0010;
         4'd2:  rom_dado = 4'b0100;
         4'd3:  rom_dado = 4'b1000;
         4'd4:  rom_dado = 4'b0100;
         4'd5:  rom_dado = 4'b0010;
         4'd6:  rom_dado = 4'b0001;
         4'd7:  rom_dado = 4'b0001;
         4'd8:  rom_dado = 4'b0010;
         4'd9:  rom_dado = 4'b0010;
         4'd10: rom_dado = 4'b0100;
         4'd11: rom_dado = 4'b0100;
         4'd12: rom_dado = 4'b1000;
         4'd13: rom_dado = 4'b1000;
         4'd14: rom_dado = 4'b0001;
         4'd15: rom_dado = 4'b0100;
         default: rom_dado = 4'b0001;
      endcase
   end

   // Status flags and debug taps.
   always_comb begin
      igual         = (rom_dado == jogada_q);
      fim           = (contagem_q == 4'd15);
      db_tem_jogada = tem;
      db_contagem   = contagem_q;
      db_jogada     = jogada_q;
      db_memoria    = rom_dado;
   end

endmodule

// File: doc/fluxo_dados.md
# fluxo_dados

Datapath for the memory-sequence game, paired with the game control FSM. It holds the sequence position counter, the 16×4 sequence ROM, the player-move register, the move comparator, and a synchronised edge detector on the four player buttons. It consumes the control strobes `zeraC`, `contaC`, `zeraR` and `registraR`, and returns the status flags `jogada_feita`, `igual` and `fim`.

## Interface
No parameters; widths are fixed (4-bit address, 4-bit data, 16 entries).

- clock  in  1  system clock; all flops update on the rising edge
- reset  in  1  asynchronous, active-high; clears every flop
- zeraC  in  1  synchronous clear of the position counter
- contaC  in  1  increment the position counter
- zeraR  in  1  synchronous clear of the move register
- registraR  in  1  load the synchronised buttons into the move register
- botoes  in  4  raw player buttons, active-high, asynchronous to clock
- jogada_feita  out  1  one-cycle pulse when any button goes from released to pressed
- igual  out  1  ROM word at the current position equals the move register
- fim  out  1  position counter = 15 (last sequence entry)
- db_tem_jogada  out  1  OR of the synchronised buttons
- db_contagem  out  4  position counter value
- db_jogada  out  4  move register value
- db_memoria  out  4  ROM word at the current position

## Operation
- **Synchroniser**
  - `botoes` passes through two flop stages to produce `botoes_s`.
  - Reset value of both stages is 0000.
- **Edge detector**
  - `tem = |botoes_s`.
  - Flop `tem_d <= tem`, reset value 0.
  - `jogada_feita = tem & ~tem_d`.
  - A button held for any length of time produces exactly one pulse.
  - Pressing a second button while one is already held produces no pulse.
  - A new pulse needs all buttons released (`tem` = 0 for at least 1 cycle) first.
- **Position counter** (4-bit)
  - Priority: `zeraC` sets it to 0, else `contaC` increments it, else it holds.
  - Wraps from 15 to 0 on `contaC`.
  - Reset value 0.
- **Move register** (4-bit)
  - Priority: `zeraR` sets it to 0000, else `registraR` loads `botoes_s`, else it holds.
  - Reset value 0000.
  - Loads a multi-hot code unchanged.
- **ROM**
  - Combinational read, addressed by the position counter.
  - Contents for addresses 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- **Status outputs**
  - `igual = (rom == move register)`, 4-bit equality, combinational.
  - `fim = (counter == 4'd15)`, combinational.
- **Values after reset**
  - db_contagem = 0, db_jogada = 0000, db_memoria = 0001, igual = 0, fim = 0, jogada_feita = 0, db_tem_jogada = 0.

## Timing
- A button press first sampled at edge E0:
  - `botoes_s` reflects it after E1.
  - `jogada_feita` is high from E1 to E2, for exactly one cycle.
- Move register:
  - With `registraR` high in the cycle before edge En, the register, `db_jogada` and `igual` reflect `botoes_s` after En.
  - With the FSM flow espera → registra → compara, `igual` is valid during compara.
- Counter:
  - With `contaC` high before edge En, `db_contagem`, `db_memoria`, `fim` and `igual` update after En.
  - These outputs change with no extra latency because the ROM read is combinational.
- `igual`, `fim` and `db_*` are glitch-tolerant combinational outputs. The FSM samples them only at clock edges.
- Asynchronous `reset` asserted mid-sequence:
  - All flops clear immediately, without waiting for a clock edge.
  - A `jogada_feita` pulse in progress is cut short.
  - While buttons are still held at reset release, `tem_d` needs 2 cycles to catch up. The edge detector therefore fires once after reset release if a button is still held; this is accepted behaviour.
- Simultaneous strobes:
  - `zeraC`+`contaC` gives counter = 0.
  - `zeraR`+`registraR` gives register = 0000.
  - `contaC`+`registraR` in the same cycle are independent; both take effect.

## Test plan
- **Reset:** assert `reset` mid-count at counter = 5 → all flops clear immediately; db_contagem = 0, db_memoria = 0001, db_jogada = 0000, igual = 0, fim = 0.
- **Edge pulse:** press `botoes` = 0100 and hold for 10 cycles → exactly one `jogada_feita` pulse, 2 edges after the press is sampled. Release, then press 0100 again → a second single pulse.
- **Register and compare:** at counter = 2, press 0100 and pulse `registraR` → db_jogada = 0100, igual = 1. Repeat with 1000 → igual = 0. Pulse `zeraR` with `registraR` → db_jogada = 0000.
- **Full walk:** apply 15 `contaC` pulses and check db_memoria against the ROM table at every address → fim = 1 only at 15. A 16th pulse → counter = 0, fim = 0.
- **Clear priority:** `zeraC` and `contaC` together at counter = 7 → counter = 0.
- **Multi-button:** press 0011 → one `jogada_feita` pulse; register loads 0011; igual = 0 at every address.
